pc_sequencer: RTL

- Multicycle fetch/execute sequencer that drives the program counter's pc_en and PCSrc inputs.
- Arbitrates the single memory port between instruction fetch and data access.
- Waits on ihit/dhit and latches decoded control-flow flags across the data phase.
- Latches halt and flags stuck memory accesses.
- Sits between decode/ALU compare and the PC block in the single-cycle-memory-port datapath.

---
 rtl/cpu_types_pkg.sv | 33 +++
 rtl/seq_wait_timer.sv | 33 +++
 rtl/pc_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared sequencer state and PC source encodings
package cpu_types_pkg;

    typedef enum logic [1:0] {
        IFETCH = 2'd0,
        DMEM   = 2'd1,
        HALTED = 2'd2
    } pcseq_state_t;

    // PC block decodes exactly these values for its next-PC mux.
    localparam logic [1:0] PCSRC_JR  = 2'd0;
    localparam logic [1:0] PCSRC_J   = 2'd1;
    localparam logic [1:0] PCSRC_BR  = 2'd2;
    localparam logic [1:0] PCSRC_SEQ = 2'd3;

    // A not-taken branch must fall through to PC+4, never to the branch target.
    function automatic logic [1:0] pcsrc_select(
        input logic is_jr,
        input logic is_j,
        input logic is_branch,
        input logic branch_taken
    );
        if (is_jr)
            return PCSRC_JR;
        else if (is_j)
            return PCSRC_J;
        else if (is_branch && branch_taken)
            return PCSRC_BR;
        else
            return PCSRC_SEQ;
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - saturating wait counter with sticky timeout flag
module seq_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic wait_cycle,
    input  logic clear,
    output logic timeout
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    logic [TIMEOUT_W-1:0] count;

    // The flag is set one edge after the count reaches the limit, even if the
    // access completes in that same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            if (count == LIMIT)
                timeout <= 1'b1;
            if (clear)
                count <= '0;
            else if (wait_cycle && (count != LIMIT))
                count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multicycle fetch/execute sequencer; PC_SEQ_PERF_CNT_EN adds perf counters
module pc_sequencer
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dREN_req,
    input  logic        dWEN_req,
    input  logic        is_jr,
    input  logic        is_j,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic        halt_req,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        imemREN,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic        halt,
    output logic        mem_timeout
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] instr_count,
    output logic [31:0] stall_count
`endif
);

    pcseq_state_t state, next_state;
    logic         lat_dren, lat_dwen;
    logic [1:0]   lat_pcsrc;
    logic         wait_cycle, timer_clear;

    always_comb begin
        next_state = state;
        pc_en      = 1'b0;
        pc_src     = PCSRC_SEQ;
        imemREN    = 1'b0;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        halt       = 1'b0;
        wait_cycle = 1'b0;
        unique case (state)
            IFETCH: begin
                imemREN    = 1'b1;
                pc_src     = pcsrc_select(is_jr, is_j, is_branch, branch_taken);
                wait_cycle = !ihit;
                if (ihit) begin
                    if (halt_req)
                        next_state = HALTED;
                    else if (dREN_req || dWEN_req)
                        next_state = DMEM;
                    else
                        pc_en = 1'b1;
                end
            end
            DMEM: begin
                dmemREN    = lat_dren;
                dmemWEN    = lat_dwen;
                pc_src     = lat_pcsrc;
                wait_cycle = !dhit;
                if (dhit) begin
                    pc_en      = 1'b1;
                    next_state = IFETCH;
                end
            end
            HALTED: begin
                halt = 1'b1;
            end
            default: begin
                next_state = IFETCH;
            end
        endcase
    end

    // Decode flags are captured at the fetch so the data phase is immune to
    // decode inputs changing once the next instruction word starts arriving.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IFETCH;
            lat_dren  <= 1'b0;
            lat_dwen  <= 1'b0;
            lat_pcsrc <= PCSRC_SEQ;
        end else begin
            state <= next_state;
            if ((state == IFETCH) && (next_state == DMEM)) begin
                lat_dren  <= dREN_req;
                lat_dwen  <= dWEN_req;
                lat_pcsrc <= pcsrc_select(is_jr, is_j, is_branch, branch_taken);
            end
        end
    end

    assign timer_clear = (next_state != state) || pc_en;

    seq_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_wait_timer (
        .CLK        (CLK),
        .RST        (RST),
        .wait_cycle (wait_cycle),
        .clear      (timer_clear),
        .timeout    (mem_timeout)
    );

`ifdef PC_SEQ_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_count <= '0;
            stall_count <= '0;
        end else if (state != HALTED) begin
            if (pc_en)
                instr_count <= instr_count + 32'd1;
            if ((state == DMEM) || ((state == IFETCH) && !ihit))
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
